// File: rtl/sb_3320_motion_sequencer.sv
// Line-following motion sequencer: follows the line, counts nodes and executes one
// buffered node action (halt/straight/left/right/u-turn) per node, with turn timeout.
`timescale 1ns/1ps
module sb_3320_motion_sequencer #(
  parameter int unsigned CLEAR_CYCLES = 5000000,
  parameter int unsigned MIN_TURN     = 10000000,
  parameter int unsigned MAX_TURN     = 100000000
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] sensor,
  input  logic       node,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  output logic       cmd_ready,
  output logic [2:0] turn,
  output logic [7:0] node_count,
  output logic       done,
  output logic       fault
);

  localparam int unsigned TW = $clog2(MAX_TURN + 1);
  localparam logic [TW-1:0] ClearLast = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] MinTurn   = TW'(MIN_TURN);
  localparam logic [TW-1:0] MaxLast   = TW'(MAX_TURN - 1);

  localparam logic [2:0] TurnStop  = 3'b000;
  localparam logic [2:0] TurnFwd   = 3'b001;
  localparam logic [2:0] TurnLeft  = 3'b010;
  localparam logic [2:0] TurnRight = 3'b011;
  localparam logic [2:0] TurnExt   = 3'b100;

  localparam logic [2:0] OpStraight = 3'b001;
  localparam logic [2:0] OpLeft     = 3'b010;
  localparam logic [2:0] OpRight    = 3'b011;
  localparam logic [2:0] OpUturn    = 3'b100;

  typedef enum logic [2:0] {StIdle, StFollow, StWait, StClear, StTurn} state_e;

  state_e        state_q, state_d;
  logic [2:0]    turn_q, turn_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic [7:0]    count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          buf_valid_q, buf_valid_d;
  logic [2:0]    buf_op_q, buf_op_d;
  logic [2:0]    act_op_q, act_op_d;
  logic          node_q;

  logic node_evt, dispatch, turn_exit, turn_timeout;

  function automatic logic is_move(input logic [2:0] op);
    return (op == OpStraight) || (op == OpLeft) || (op == OpRight) || (op == OpUturn);
  endfunction

  // A fully dark sensor bar keeps steering the way we were already going.
  function automatic logic [2:0] follow_code(input logic [2:0] s, input logic [2:0] prev);
    logic [2:0] code;
    case (s)
      3'b010, 3'b111, 3'b101: code = TurnFwd;
      3'b100, 3'b110:         code = TurnLeft;
      3'b001, 3'b011:         code = TurnRight;
      default:                code = prev;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] turn_code(input logic [2:0] op);
    logic [2:0] code;
    case (op)
      OpLeft:  code = TurnLeft;
      OpRight: code = TurnRight;
      default: code = TurnExt;
    endcase
    return code;
  endfunction

  assign node_evt     = enable && (state_q == StFollow) && node && !node_q;
  assign dispatch     = buf_valid_q && (node_evt || (enable && (state_q == StWait)));
  assign turn_exit    = (timer_q >= MinTurn) && sensor[1];
  // Timeout fires on the edge the timer would reach MAX_TURN.
  assign turn_timeout = (timer_q >= MaxLast);

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      turn_q      <= TurnStop;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      count_q     <= 8'd0;
      timer_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_op_q    <= 3'b000;
      act_op_q    <= 3'b000;
      node_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      buf_valid_q <= buf_valid_d;
      buf_op_q    <= buf_op_d;
      act_op_q    <= act_op_d;
      node_q      <= node;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   if (!fault_q) state_d = StFollow;
        StFollow: if (node_evt) state_d = buf_valid_q ? (is_move(buf_op_q) ? StClear : StIdle)
                                                      : StWait;
        StWait:   if (buf_valid_q) state_d = is_move(buf_op_q) ? StClear : StIdle;
        StClear:  if (timer_q == ClearLast) state_d = (act_op_q == OpStraight) ? StFollow
                                                                               : StTurn;
        StTurn: begin
          if (turn_exit)         state_d = StFollow;
          else if (turn_timeout) state_d = StIdle;
        end
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    turn_d      = TurnStop;
    count_d     = count_q + {7'd0, node_evt};
    act_op_d    = dispatch ? buf_op_q : act_op_q;
    buf_op_d    = buf_op_q;
    buf_valid_d = buf_valid_q;
    if (dispatch) begin
      buf_valid_d = 1'b0;
    end else if (cmd_valid && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      buf_op_d    = cmd_op;
    end

    case (state_d)
      StFollow: turn_d = follow_code(sensor, turn_q);
      StClear:  turn_d = TurnFwd;
      StTurn:   turn_d = turn_code(act_op_d);
      default:  turn_d = TurnStop;
    endcase

    if ((state_d == state_q) && ((state_q == StClear) || (state_q == StTurn))) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = '0;
    end

    done_d  = (dispatch && !is_move(buf_op_q)) ||
              ((state_d == StFollow) && ((state_q == StClear) || (state_q == StTurn)));
    fault_d = fault_q || (enable && (state_q == StTurn) && !turn_exit && turn_timeout);
  end

  assign cmd_ready  = !buf_valid_q;
  assign turn       = turn_q;
  assign node_count = count_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule

// File: doc/sb_3320_motion_sequencer.md
SB_3320_MOTION_SEQUENCER -- requirements
Module: sb_3320_motion_sequencer

Interface
REQ-001 Parameter CLEAR_CYCLES, default 5000000, forward-drive cycles to clear a node before turning.
REQ-002 Parameter MIN_TURN, default 10000000, minimum cycles a turn code is held.
REQ-003 Parameter MAX_TURN, default 100000000, turn timeout in cycles; MAX_TURN > MIN_TURN.
REQ-004 clk_50  in  1  system clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 enable  in  1  run permission, level.
REQ-007 sensor  in  3  line sensors {left,centre,right}, 1 = line present.
REQ-008 node  in  1  node-detect level.
REQ-009 cmd_valid  in  1  node-action command offered.
REQ-010 cmd_op  in  3  action: 000 halt, 001 straight, 010 left, 011 right, 100 u-turn; 101-111 treated as halt.
REQ-011 cmd_ready  out  1  command buffer empty.
REQ-012 turn  out  3  motor code: 000 stop, 001 forward, 010 left, 011 right, 100 extreme.
REQ-013 node_count  out  8  nodes detected, wraps.
REQ-014 done  out  1  one-cycle action-complete pulse.
REQ-015 fault  out  1  sticky turn-timeout flag.

Function
REQ-016 One-entry command buffer SHALL load on cmd_valid & cmd_ready; cmd_ready = buffer empty; no same-cycle load and pop.
REQ-017 States SHALL be IDLE, FOLLOW, WAIT, CLEAR, TURN; turn, done, fault, node_count are registered.
REQ-018 IDLE: turn=000; enable=1 and fault=0 -> FOLLOW.
REQ-019 enable=0 in any state SHALL force IDLE next cycle with turn=000; buffer and node_count retained.
REQ-020 FOLLOW turn from sensor: 010/111 -> 001, 100/110 -> 010, 001/011 -> 011, 101 -> 001, 000 -> hold previous code.
REQ-021 Node event = rising edge of node (registered previous value), recognised only in FOLLOW; edges in other states ignored.
REQ-022 On node event node_count SHALL increment (255 -> 0); buffer empty -> WAIT, else pop buffer and dispatch per REQ-024.
REQ-023 WAIT: turn=000; buffer becomes non-empty -> pop and dispatch next cycle.
REQ-024 Dispatch: halt/invalid op -> IDLE with done pulse; other ops -> CLEAR with timer cleared.
REQ-025 CLEAR: turn=001 for exactly CLEAR_CYCLES cycles; then straight -> FOLLOW with done pulse, left/right/u-turn -> TURN with timer cleared.
REQ-026 TURN: turn=010 left, 011 right, 100 u-turn; exit to FOLLOW with done pulse when timer >= MIN_TURN and sensor[1]=1.
REQ-027 TURN timer reaching MAX_TURN without exit SHALL set fault, go IDLE, turn=000; fault holds IDLE until reset.
REQ-028 Sensor-to-turn latency in FOLLOW SHALL be one cycle; state entry sets the new turn code on the same edge.
REQ-029 Timer width SHALL cover MAX_TURN without overflow.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, turn=000, buffer empty, cmd_ready=1, node_count=0, done=0, fault=0, node history=0.
REQ-031 rst asserted mid-CLEAR/TURN SHALL abandon the action with no done pulse; deassertion resumes in IDLE.

Verification (CLEAR_CYCLES=4, MIN_TURN=6, MAX_TURN=20)
V-1 enable=1, sensor 010 then 100 then 000 -> turn 001, 010, 010 (held), each one cycle after input.
V-2 buffer left, node rising edge -> node_count=1, cmd_ready=1, 4 cycles turn=001, >=6 cycles turn=010, sensor[1]=1 -> FOLLOW, done pulse.
V-3 node edge with empty buffer -> WAIT turn=000; push u-turn -> CLEAR 4 cycles then turn=100.
V-4 TURN with sensor=000 -> fault=1 after 20 cycles, turn=000, IDLE persists with enable=1 until rst.
V-5 cmd_op=110 popped at node -> IDLE, turn=000, done pulse; second push while buffer full -> cmd_ready=0, no load.
V-6 256 straight nodes -> node_count wraps to 0; rst mid-TURN -> all outputs reset values, no done.
